// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) round-robin arbiter for a single unified memory port,
// with registered outputs and a saturating wait-counter timeout abort.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        CpuReq,
    input  logic        CpuWe,
    input  logic [31:0] CpuAdr,
    input  logic [31:0] CpuWData,
    output logic [31:0] CpuRData,
    output logic        CpuAck,
    input  logic        DmaReq,
    input  logic        DmaWe,
    input  logic [31:0] DmaAdr,
    input  logic [31:0] DmaWData,
    output logic [31:0] DmaRData,
    output logic        DmaAck,
    output logic        AckErr,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] MemAdr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemReadData,
    input  logic        MemReady,
    output logic        Busy
);

    typedef enum logic [1:0] {StIdle, StGrantCpu, StGrantDma} state_e;

    state_e      state_q, state_d;
    logic        last_dma_q, last_dma_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_adr_q, mem_adr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;
    logic        ack_err_q, ack_err_d;
    logic        busy_q, busy_d;

    logic        cpu_elig, dma_elig;
    logic        grant_cpu, grant_dma;
    logic        timeout_hit;
    logic        finish;
    logic [31:0] rdata;

    // A requester whose Ack is currently high is masked for this cycle.
    assign cpu_elig    = CpuReq && !cpu_ack_q;
    assign dma_elig    = DmaReq && !dma_ack_q;
    assign grant_cpu   = cpu_elig && (!dma_elig || last_dma_q);
    assign grant_dma   = dma_elig && (!cpu_elig || !last_dma_q);
    assign timeout_hit = (32'(cnt_q) + 32'd1) >= 32'(TIMEOUT);

    always_comb begin
        state_d     = state_q;
        last_dma_d  = last_dma_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        busy_d      = busy_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        ack_err_d   = 1'b0;
        finish      = 1'b0;
        rdata       = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (grant_cpu) begin
                    state_d     = StGrantCpu;
                    mem_adr_d   = CpuAdr;
                    mem_write_d = CpuWe;
                    mem_wdata_d = CpuWData;
                    mem_req_d   = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = 8'd0;
                end else if (grant_dma) begin
                    state_d     = StGrantDma;
                    mem_adr_d   = DmaAdr;
                    mem_write_d = DmaWe;
                    mem_wdata_d = DmaWData;
                    mem_req_d   = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = 8'd0;
                end
            end
            StGrantCpu, StGrantDma: begin
                // MemReady takes priority over a coincident timeout.
                if (MemReady) begin
                    finish = 1'b1;
                    rdata  = mem_write_q ? 32'd0 : MemReadData;
                end else if (timeout_hit) begin
                    finish    = 1'b1;
                    ack_err_d = 1'b1;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (finish) begin
                    state_d     = StIdle;
                    mem_req_d   = 1'b0;
                    mem_write_d = 1'b0;
                    busy_d      = 1'b0;
                    if (state_q == StGrantCpu) begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = rdata;
                        last_dma_d  = 1'b0;
                    end else begin
                        dma_ack_d   = 1'b1;
                        dma_rdata_d = rdata;
                        last_dma_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            last_dma_q  <= 1'b1;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_adr_q   <= 32'd0;
            mem_wdata_q <= 32'd0;
            cpu_rdata_q <= 32'd0;
            dma_rdata_q <= 32'd0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            ack_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dma_q  <= last_dma_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            ack_err_q   <= ack_err_d;
            busy_q      <= busy_d;
        end
    end

    assign CpuRData = cpu_rdata_q;
    assign CpuAck   = cpu_ack_q;
    assign DmaRData = dma_rdata_q;
    assign DmaAck   = dma_ack_q;
    assign AckErr   = ack_err_q;
    assign MemReq   = mem_req_q;
    assign MemWrite = mem_write_q;
    assign MemAdr   = mem_adr_q;
    assign MemWData = mem_wdata_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed expectations checked with
// immediate assertions one clock-plus-1 after each rising edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        CpuReq = 1'b0, CpuWe = 1'b0;
    logic [31:0] CpuAdr = '0, CpuWData = '0;
    logic [31:0] CpuRData;
    logic        CpuAck;
    logic        DmaReq = 1'b0, DmaWe = 1'b0;
    logic [31:0] DmaAdr = '0, DmaWData = '0;
    logic [31:0] DmaRData;
    logic        DmaAck, AckErr, MemReq, MemWrite, Busy;
    logic [31:0] MemAdr, MemWData;
    logic [31:0] MemReadData = '0;
    logic        MemReady = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int early_acks;

    mem_arbiter #(.TIMEOUT(255)) dut (
        .clk(clk), .Reset(Reset),
        .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAdr(CpuAdr), .CpuWData(CpuWData),
        .CpuRData(CpuRData), .CpuAck(CpuAck),
        .DmaReq(DmaReq), .DmaWe(DmaWe), .DmaAdr(DmaAdr), .DmaWData(DmaWData),
        .DmaRData(DmaRData), .DmaAck(DmaAck), .AckErr(AckErr),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemAdr(MemAdr), .MemWData(MemWData),
        .MemReadData(MemReadData), .MemReady(MemReady), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        step();
    endtask

    initial begin
        // Reset values, checked before any clock edge
        #2 Reset = 1'b1;
        #1;
        check("rst_memreq", 32'(MemReq), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_memadr", MemAdr, 32'd0);
        check("rst_cpurdata", CpuRData, 32'd0);
        check("rst_acks", {29'd0, CpuAck, DmaAck, AckErr}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        step();

        // CPU read
        CpuReq = 1'b1; CpuAdr = 32'h100; CpuWe = 1'b0;
        step();
        check("rd_memreq", 32'(MemReq), 32'd1);
        check("rd_memadr", MemAdr, 32'h100);
        check("rd_memwrite", 32'(MemWrite), 32'd0);
        check("rd_busy", 32'(Busy), 32'd1);
        MemReady = 1'b1; MemReadData = 32'hE3A00005; CpuReq = 1'b0;
        step();
        check("rd_ack", {30'd0, CpuAck, AckErr}, 32'd2);
        check("rd_rdata", CpuRData, 32'hE3A00005);
        check("rd_memreq_off", 32'(MemReq), 32'd0);
        // MemReady stays high while idle: must be ignored
        MemReadData = 32'h0BAD0BAD;
        step();
        step();
        check("idle_ready_ign", {29'd0, CpuAck, DmaAck, Busy}, 32'd0);
        check("rd_rdata_hold", CpuRData, 32'hE3A00005);
        MemReady = 1'b0;

        // Ties after reset: CPU first, then DMA, then CPU
        pulse_reset();
        CpuReq = 1'b1; DmaReq = 1'b1; CpuAdr = 32'h100; DmaAdr = 32'h200;
        MemReady = 1'b1; MemReadData = 32'h11111111;
        step();
        check("tie1_adr", MemAdr, 32'h100);
        step();
        check("tie1_cpuack", 32'(CpuAck), 32'd1);
        check("tie1_rdata", CpuRData, 32'h11111111);
        MemReadData = 32'h22222222;
        step();
        check("tie2_adr", MemAdr, 32'h200);
        check("tie2_memreq", 32'(MemReq), 32'd1);
        step();
        check("tie2_dmaack", 32'(DmaAck), 32'd1);
        check("tie2_rdata", DmaRData, 32'h22222222);
        check("tie2_cpu_hold", CpuRData, 32'h11111111);
        step();
        check("tie3_adr", MemAdr, 32'h100);
        CpuReq = 1'b0; DmaReq = 1'b0;
        step();
        check("tie3_cpuack", 32'(CpuAck), 32'd1);
        MemReady = 1'b0;
        step();

        // DMA write with MemReady delayed 5 cycles
        DmaReq = 1'b1; DmaWe = 1'b1; DmaAdr = 32'h40; DmaWData = 32'hDEADBEEF;
        step();
        check("wr_memwrite_0", 32'(MemWrite), 32'd1);
        DmaAdr = 32'h44; DmaWData = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wr_memwrite_n", 32'(MemWrite), 32'd1);
            check("wr_memadr_n", MemAdr, 32'h40);
            check("wr_memwdata_n", MemWData, 32'hDEADBEEF);
        end
        MemReady = 1'b1; MemReadData = 32'h55555555;
        step();
        check("wr_dmaack", {30'd0, DmaAck, AckErr}, 32'd2);
        check("wr_rdata", DmaRData, 32'd0);
        check("wr_memwrite_off", 32'(MemWrite), 32'd0);
        MemReady = 1'b0; DmaReq = 1'b0; DmaWe = 1'b0;
        step();

        // Timeout: Req dropped after grant must not abort early
        CpuReq = 1'b1; CpuAdr = 32'h300;
        step();
        CpuReq = 1'b0;
        early_acks = 0;
        for (int i = 0; i < 254; i++) begin
            step();
            if (CpuAck || !MemReq) early_acks++;
        end
        check("to_no_early_ack", 32'(early_acks), 32'd0);
        step();
        check("to_ack_err", {30'd0, CpuAck, AckErr}, 32'd3);
        check("to_rdata", CpuRData, 32'd0);
        check("to_memreq", 32'(MemReq), 32'd0);
        step();
        check("to_err_pulse", 32'(AckErr), 32'd0);

        // MemReady on the timeout edge wins
        CpuReq = 1'b1; CpuAdr = 32'h304;
        step();
        CpuReq = 1'b0;
        for (int i = 0; i < 254; i++) step();
        MemReady = 1'b1; MemReadData = 32'hA5A5A5A5;
        step();
        check("to_tie_ack", {30'd0, CpuAck, AckErr}, 32'd2);
        check("to_tie_rdata", CpuRData, 32'hA5A5A5A5);
        MemReady = 1'b0;
        step();

        // Reset mid GRANT_DMA (last grant is CPU here, so a tie would go to DMA)
        DmaReq = 1'b1; DmaAdr = 32'h500; CpuAdr = 32'h600;
        step();
        check("rm_grant", MemAdr, 32'h500);
        step();
        #2 Reset = 1'b1;
        #1;
        check("rm_memreq_now", 32'(MemReq), 32'd0);
        check("rm_busy_now", 32'(Busy), 32'd0);
        @(negedge clk);
        check("rm_no_dmaack", 32'(DmaAck), 32'd0);
        Reset = 1'b0; CpuReq = 1'b1;
        step();
        check("rm_tie_cpu", MemAdr, 32'h600);
        CpuReq = 1'b0; DmaReq = 1'b0; MemReady = 1'b1;
        step();
        check("rm_cpuack", 32'(CpuAck), 32'd1);
        MemReady = 1'b0;
        step();

        // Back-to-back CPU reads: Ack every 3 cycles
        CpuReq = 1'b1; MemReady = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check("b2b_ack", 32'(CpuAck), (i % 3 == 1) ? 32'd1 : 32'd0);
            check("b2b_busy", 32'(Busy), (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        CpuReq = 1'b0; MemReady = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk, Reset.
REQ-002 Port list (name  direction  width  meaning) SHALL be:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- CpuReq  in  1  CPU requests memory access
- CpuWe  in  1  CPU access is a write
- CpuAdr  in  32  CPU byte address
- CpuWData  in  32  CPU write data
- CpuRData  out  32  CPU read data, valid when CpuAck=1
- CpuAck  out  1  one-cycle completion pulse to CPU
- DmaReq  in  1  loader/DMA requests memory access
- DmaWe  in  1  DMA access is a write
- DmaAdr  in  32  DMA byte address
- DmaWData  in  32  DMA write data
- DmaRData  out  32  DMA read data, valid when DmaAck=1
- DmaAck  out  1  one-cycle completion pulse to DMA
- AckErr  out  1  qualifies the current Ack as a timeout abort
- MemReq  out  1  access to the unified memory in progress
- MemWrite  out  1  memory write enable
- MemAdr  out  32  memory address
- MemWData  out  32  memory write data
- MemReadData  in  32  memory read data
- MemReady  in  1  memory completes the current access
- Busy  out  1  arbiter is not in IDLE
REQ-003 Timeout limit parameter: TIMEOUT, default 255, maximum number of GRANT cycles without MemReady.

Function
REQ-004 The FSM SHALL have three states: IDLE, GRANT_CPU and GRANT_DMA. All outputs SHALL be registered.
REQ-005 In IDLE, requests SHALL be sampled at the rising edge:
- only one eligible request: grant that requester
- both eligible: grant the requester other than LastGrant (round-robin)
- LastGrant SHALL reset to DMA, so the CPU wins the first tie
REQ-006 On a grant edge the block SHALL:
- latch the requester's Adr, We and WData into MemAdr, MemWrite and MemWData
- set MemReq=1 and Busy=1
- clear the wait counter
REQ-007 In GRANT_x, MemReq, MemAdr, MemWrite and MemWData SHALL hold constant. Requester inputs SHALL be ignored.
REQ-008 In GRANT_x with MemReady=1 at an edge, the block SHALL:
- capture MemReadData into xRData (writes capture 0)
- pulse xAck=1 with AckErr=0 for one cycle
- drive MemReq=0, MemWrite=0 and Busy=0
- set LastGrant=x and return to IDLE
REQ-009 Minimum latency: Req high at edge k gives MemReq high after edge k. MemReady high at edge k+1 gives Ack high after edge k+1.
REQ-010 The wait counter (8-bit, saturating) SHALL increment on each GRANT cycle with MemReady=0. When it reaches TIMEOUT with MemReady still 0, the block SHALL:
- abort the access
- pulse xAck=1 with AckErr=1 and xRData=0
- drop MemReq and return to IDLE
REQ-011 If MemReady and timeout occur on the same edge, MemReady SHALL win: a normal Ack with AckErr=0.
REQ-012 In the cycle an Ack is high, the acknowledged requester's Req SHALL be masked. The other requester is eligible. A held Req is re-sampled one cycle later, so back-to-back transactions from one requester are spaced by at least one IDLE cycle.
REQ-013 xRData SHALL hold its value until the next Ack to the same requester.
REQ-014 MemReady asserted while in IDLE SHALL be ignored.
REQ-015 Requesters SHALL hold Req, We, Adr and WData stable until Ack. Deasserting Req while granted SHALL NOT abort the access.

Reset
REQ-016 Asserting Reset SHALL immediately, without waiting for clk, force:
- state=IDLE, LastGrant=DMA, counter=0
- MemReq=0, MemWrite=0, MemAdr=0, MemWData=0
- CpuAck=0, DmaAck=0, AckErr=0, Busy=0
- CpuRData=0, DmaRData=0
REQ-017 Reset mid-GRANT SHALL abandon the access with no Ack issued. The first grant after release SHALL follow REQ-005.

Verification
REQ-018 CPU read: CpuReq=1, CpuAdr=0x100, CpuWe=0; MemReady=1 one cycle later with MemReadData=0xE3A00005 -> MemAdr=0x100 and MemReq=1 for one cycle, then CpuAck=1 with CpuRData=0xE3A00005 and AckErr=0.
REQ-019 Simultaneous requests: CpuReq=DmaReq=1 after reset -> CPU granted first; DMA granted after CpuAck; a third tie grants the CPU.
REQ-020 DMA write: DmaWe=1, DmaAdr=0x40, DmaWData=0xDEADBEEF, MemReady delayed 5 cycles -> MemWrite=1 held 6 cycles with stable address and data; DmaAck=1; DmaRData=0.
REQ-021 Timeout: CPU read with MemReady held at 0 -> CpuAck=1, AckErr=1, CpuRData=0 after 255 wait cycles; MemReq=0 in that same Ack cycle.
REQ-022 Reset mid-access: Reset pulsed during GRANT_DMA -> MemReq=0 immediately; no DmaAck; a later CPU-vs-DMA tie is won by the CPU.
REQ-023 Back-to-back: CpuReq held high, DmaReq=0, MemReady=1 always -> CpuAck pulses every 3 cycles, with one IDLE gap between transactions.
